pipeline_hazard_ctrl: RTL and testbench

Central pipeline controller for the 5-stage ARM core. Detects RAW hazards between the instruction in ID and the destinations held in EXE/MEM, inserts bubbles into the ID/EX stage register via its Flush input, and squashes IF/ID and ID/EX on a taken branch. It also freezes the whole pipeline while a multi-cycle SRAM access in MEM is outstanding. Sits beside the ID stage and drives the PC, IF/ID, ID/EX and global freeze controls.

---
 rtl/pipeline_hazard_ctrl.sv | 86 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: RAW stall, branch squash and SRAM-wait freeze control for the 5-stage core.
// Define PERF_COUNTERS_EN to build saturating stall/flush/freeze counters (width CNT_W).
module pipeline_hazard_ctrl
`ifdef PERF_COUNTERS_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] id_src1,
  input  logic [3:0] id_src2,
  input  logic       id_use_src1,
  input  logic       id_two_src,
  input  logic [3:0] exe_dest,
  input  logic       exe_wb_en,
  input  logic       exe_mem_r_en,
  input  logic [3:0] mem_dest,
  input  logic       mem_wb_en,
  input  logic       fwd_en,
  input  logic       branch_taken,
  input  logic       mem_start,
  input  logic       mem_ready,
  output logic       pc_freeze,
  output logic       if_id_freeze,
  output logic       if_flush,
  output logic       id_flush,
  output logic       pipe_freeze,
  output logic [1:0] ctrl_state
`ifdef PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
`endif
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1} state_t;
  state_t state, state_nx;
  logic id_valid, id_valid_nx;
  logic mem_wait, hazard, stall, flush;
  function automatic logic match(input logic [3:0] r);
    return fwd_en ? (exe_wb_en & exe_mem_r_en & (exe_dest == r))
                  : ((exe_wb_en & (exe_dest == r)) | (mem_wb_en & (mem_dest == r)));
  endfunction
  assign mem_wait = (state == RUN) ? (mem_start & ~mem_ready) : ~mem_ready;
  assign hazard = id_valid & ((id_use_src1 & match(id_src1)) | (id_two_src & match(id_src2)));
  assign flush = ~mem_wait & branch_taken;
  assign stall = ~mem_wait & ~branch_taken & hazard;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      id_valid <= 1'b1;
    end else begin
      state    <= state_nx;
      id_valid <= id_valid_nx;
    end
  end
  always_comb begin
    state_nx = (state == RUN) ? ((mem_start & ~mem_ready) ? MEM_WAIT : RUN)
                              : (mem_ready ? RUN : MEM_WAIT);
    // a stalled or frozen ID instruction keeps its validity; a branch squashes it
    id_valid_nx = (mem_wait | stall) ? id_valid : ~flush;
  end
  always_comb begin
    pipe_freeze  = mem_wait;
    pc_freeze    = mem_wait | stall;
    if_id_freeze = mem_wait | stall;
    if_flush     = flush;
    id_flush     = flush | stall;
    ctrl_state   = state;
  end
`ifdef PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
      if (flush & ~&flush_cnt) flush_cnt <= flush_cnt + 1'b1;
      if (mem_wait & ~&freeze_cnt) freeze_cnt <= freeze_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed-vector self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;
  logic clk = 0, rst = 1;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic id_use_src1, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic fwd_en, branch_taken, mem_start, mem_ready;
  logic pc_freeze, if_id_freeze, if_flush, id_flush, pipe_freeze;
  logic [1:0] ctrl_state;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
`ifdef PERF_COUNTERS_EN
  logic [1:0] stall_cnt, flush_cnt, freeze_cnt;
  pipeline_hazard_ctrl #(.CNT_W(2)) dut (
`else
  pipeline_hazard_ctrl dut (
`endif
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_two_src(id_two_src), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .fwd_en(fwd_en), .branch_taken(branch_taken),
    .mem_start(mem_start), .mem_ready(mem_ready), .pc_freeze(pc_freeze),
    .if_id_freeze(if_id_freeze), .if_flush(if_flush), .id_flush(id_flush),
    .pipe_freeze(pipe_freeze), .ctrl_state(ctrl_state)
`ifdef PERF_COUNTERS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
  );
  // {pc_freeze, if_id_freeze, if_flush, id_flush, pipe_freeze, ctrl_state}
  wire [6:0] outs = {pc_freeze, if_id_freeze, if_flush, id_flush, pipe_freeze, ctrl_state};
  localparam logic [6:0] NONE = 7'b0000000, STALL = 7'b1101000, FLUSH = 7'b0011000,
                         FRZ_RUN = 7'b1100100, FRZ_WAIT = 7'b1100101;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    {id_src1, id_src2, exe_dest, mem_dest} = '0;
    {id_use_src1, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en} = '0;
    {fwd_en, branch_taken, mem_start, mem_ready} = '0;
  endtask
  task automatic step(input string tag, input logic [6:0] exp);
    #2 chk(tag, {25'b0, outs}, {25'b0, exp});
    @(posedge clk);
    #1;
  endtask
  initial begin
    clr();
    #2 chk("reset_outs", {25'b0, outs}, 32'd0);
    @(posedge clk); #1 rst = 0;
    // load-use with forwarding: one stall, then the load sits in MEM
    fwd_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 3; id_src1 = 3; id_use_src1 = 1;
    step("loaduse_stall", STALL);
    exe_mem_r_en = 0; exe_wb_en = 0; mem_wb_en = 1; mem_dest = 3;
    step("loaduse_release", NONE);
    // no forwarding: MEM dest matches src2
    clr(); mem_wb_en = 1; mem_dest = 5; id_two_src = 1; id_src2 = 5;
    step("nofwd_mem_src2", STALL);
    id_two_src = 0;
    step("nofwd_src2_unused", NONE);
    clr(); exe_wb_en = 1; exe_dest = 7; id_src1 = 7; id_use_src1 = 1;
    step("nofwd_exe_src1", STALL);
    fwd_en = 1;
    step("fwd_exe_alu", NONE);
    // branch beats hazard, squashed ID instruction cannot stall
    fwd_en = 0; branch_taken = 1;
    step("branch_flush", FLUSH);
    branch_taken = 0;
    step("squashed_no_stall", NONE);
    step("valid_again_stall", STALL);
    // SRAM wait of 4 cycles with a branch arriving mid-wait
    clr(); mem_start = 1;
    step("wait_c0", FRZ_RUN);
    mem_start = 0;
    step("wait_c1", FRZ_WAIT);
    branch_taken = 1;
    step("wait_c2_branch", FRZ_WAIT);
    step("wait_c3_branch", FRZ_WAIT);
    mem_ready = 1;
    step("release_flush", 7'b0011001);
    clr();
    step("after_release", NONE);
    // back-to-back access completes immediately
    mem_start = 1; mem_ready = 1;
    step("b2b_no_freeze", NONE);
    clr();
    step("b2b_still_run", NONE);
    // asynchronous reset in the middle of a wait
    mem_start = 1;
    step("rwait_c0", FRZ_RUN);
    mem_start = 0;
    #2 chk("rwait_c1", {25'b0, outs}, {25'b0, FRZ_WAIT});
    rst = 1;
    #1 chk("async_reset_outs", {25'b0, outs}, 32'd0);
    @(posedge clk); #1 rst = 0;
    step("post_reset_idle", NONE);
`ifdef PERF_COUNTERS_EN
    chk("cnt_reset", {26'b0, stall_cnt, flush_cnt, freeze_cnt}, 32'd0);
    exe_wb_en = 1; exe_dest = 2; id_src1 = 2; id_use_src1 = 1;
    step("cnt_stall", STALL);
    clr(); branch_taken = 1;
    step("cnt_flush", FLUSH);
    clr(); mem_start = 1;
    step("cnt_frz0", FRZ_RUN);
    mem_start = 0;
    for (int i = 1; i < 5; i++) step("cnt_frz", FRZ_WAIT);
    mem_ready = 1;
    step("cnt_release", 7'b0000001);
    clr();
    chk("stall_cnt", {30'b0, stall_cnt}, 32'd1);
    chk("flush_cnt", {30'b0, flush_cnt}, 32'd1);
    chk("freeze_cnt_sat", {30'b0, freeze_cnt}, 32'd3);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
